// File: rtl/bp_perceptron_hashed.sv
// Hashed perceptron branch predictor: combinational prediction in fetch, an update FIFO
// fed from EX, and a serial training FSM that rewrites Lanes weights of one row per cycle.
module bp_perceptron_hashed #(
  parameter int PTableSize   = 1024,
  parameter int PWeightLen   = 9,
  parameter int GHRLen       = 12,
  parameter int Theta        = 37,
  parameter int Lanes        = 4,
  parameter int UpdFifoDepth = 4,
  parameter bit HashGhr      = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        fetch_valid_i,
  output logic        predict_branch_taken_o,
  output logic [31:0] predict_branch_pc_o,
  input  logic [31:0] ex_br_instr_addr_i,
  input  logic        ex_br_taken_i,
  input  logic        ex_br_valid_i,
  output logic        train_busy_o,
  output logic [15:0] upd_drop_cnt_o
);
  localparam int IdxW   = $clog2(PTableSize);
  localparam int W      = PWeightLen;
  localparam int SW     = PWeightLen + $clog2(GHRLen + 1) + 1;
  localparam int HashW  = (IdxW < GHRLen) ? IdxW : GHRLen;
  localparam int NSteps = (GHRLen + Lanes - 1) / Lanes;
  localparam int LaneW  = (NSteps > 1) ? $clog2(NSteps) : 1;
  localparam int PtrW   = $clog2(UpdFifoDepth);
  localparam int CntW   = $clog2(UpdFifoDepth + 1);

  typedef logic signed [W-1:0]      weight_t;
  typedef logic [GHRLen-1:0][W-1:0] row_t;
  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_WRITE} state_t;

  localparam weight_t WMax = weight_t'({1'b0, {(W-1){1'b1}}});
  localparam weight_t WMin = weight_t'({1'b1, {(W-1){1'b0}}});

  function automatic logic [IdxW-1:0] calc_idx(input logic [31:0] pc, input logic [GHRLen-1:0] ghr);
    logic [IdxW-1:0] h;
    h = '0;
    if (HashGhr) h[HashW-1:0] = ghr[HashW-1:0];
    return pc[IdxW+1:2] ^ h;
  endfunction

  // Terms are widened before negation so that -WMin cannot overflow.
  function automatic logic signed [SW-1:0] calc_y(input weight_t bias, input row_t w,
                                                  input logic [GHRLen-1:0] ghr);
    logic signed [SW-1:0] acc;
    logic signed [SW-1:0] term;
    acc = {{(SW-W){bias[W-1]}}, bias};
    for (int j = 0; j < GHRLen; j++) begin
      term = {{(SW-W){w[j][W-1]}}, w[j]};
      acc  = ghr[j] ? (acc + term) : (acc - term);
    end
    return acc;
  endfunction

  function automatic weight_t sat_step(input weight_t v, input logic up);
    weight_t r;
    r = v;
    if (up && (v != WMax))       r = v + weight_t'(1);
    else if (!up && (v != WMin)) r = v - weight_t'(1);
    return r;
  endfunction

  weight_t           r_bias [PTableSize];
  row_t              r_w    [PTableSize];
  logic [GHRLen-1:0] r_ghr;

  logic [IdxW-1:0]   r_fifo_idx   [UpdFifoDepth];
  logic              r_fifo_taken [UpdFifoDepth];
  logic [GHRLen-1:0] r_fifo_ghr   [UpdFifoDepth];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [CntW-1:0]   r_count;
  logic [15:0]       r_drop_cnt;

  state_t            r_state;
  logic [IdxW-1:0]   r_idx;
  logic              r_taken;
  logic [GHRLen-1:0] r_snap;
  logic [LaneW-1:0]  r_lane;

  // Fetch-side decode and target, same immediates as the simple static predictor.
  logic        w_instr_j, w_instr_b, w_instr_cj, w_instr_cb;
  logic [31:0] w_imm_j, w_imm_b, w_imm_cj, w_imm_cb, w_imm;
  assign w_instr_j  = (fetch_rdata_i[6:0] == 7'h6F);
  assign w_instr_b  = (fetch_rdata_i[6:0] == 7'h63);
  assign w_instr_cj = (fetch_rdata_i[1:0] == 2'b01) &&
                      ((fetch_rdata_i[15:13] == 3'b101) || (fetch_rdata_i[15:13] == 3'b001));
  assign w_instr_cb = (fetch_rdata_i[1:0] == 2'b01) && (fetch_rdata_i[15:14] == 2'b11);

  assign w_imm_j  = {{12{fetch_rdata_i[31]}}, fetch_rdata_i[19:12], fetch_rdata_i[20],
                     fetch_rdata_i[30:21], 1'b0};
  assign w_imm_b  = {{19{fetch_rdata_i[31]}}, fetch_rdata_i[31], fetch_rdata_i[7],
                     fetch_rdata_i[30:25], fetch_rdata_i[11:8], 1'b0};
  assign w_imm_cj = {{20{fetch_rdata_i[12]}}, fetch_rdata_i[12], fetch_rdata_i[8],
                     fetch_rdata_i[10:9], fetch_rdata_i[6], fetch_rdata_i[7], fetch_rdata_i[2],
                     fetch_rdata_i[11], fetch_rdata_i[5:3], 1'b0};
  assign w_imm_cb = {{23{fetch_rdata_i[12]}}, fetch_rdata_i[12], fetch_rdata_i[6:5],
                     fetch_rdata_i[2], fetch_rdata_i[11:10], fetch_rdata_i[4:3], 1'b0};

  always_comb begin
    w_imm = w_imm_b;
    if (w_instr_j)       w_imm = w_imm_j;
    else if (w_instr_cj) w_imm = w_imm_cj;
    else if (w_instr_cb) w_imm = w_imm_cb;
  end

  logic [IdxW-1:0]      w_fetch_idx;
  logic signed [SW-1:0] w_fetch_y;
  assign w_fetch_idx = calc_idx(fetch_pc_i, r_ghr);
  assign w_fetch_y   = calc_y(r_bias[w_fetch_idx], r_w[w_fetch_idx], r_ghr);

  assign predict_branch_taken_o = fetch_valid_i &
      (w_instr_j | w_instr_cj | ((w_instr_b | w_instr_cb) & ~w_fetch_y[SW-1]));
  assign predict_branch_pc_o = fetch_pc_i + w_imm;

  logic w_pop, w_full, w_push;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
  assign w_full = (r_count == CntW'(UpdFifoDepth));
  assign w_push = ex_br_valid_i && (!w_full || w_pop);

  logic [IdxW-1:0] w_push_idx;
  logic            w_unused;
  assign w_push_idx = calc_idx(ex_br_instr_addr_i, r_ghr);
  assign w_unused   = ^{ex_br_instr_addr_i[31:IdxW+2], ex_br_instr_addr_i[1:0]};

  logic signed [SW-1:0] w_eval_y;
  logic signed [31:0]   w_y32, w_abs32;
  logic                 w_train;
  assign w_eval_y = calc_y(r_bias[r_idx], r_w[r_idx], r_snap);
  assign w_y32    = {{(32-SW){w_eval_y[SW-1]}}, w_eval_y};
  assign w_abs32  = w_y32[31] ? -w_y32 : w_y32;
  assign w_train  = ((w_eval_y[SW-1]) == r_taken) || (w_abs32 <= Theta);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_idx[r_wptr]   <= w_push_idx;
      r_fifo_taken[r_wptr] <= ex_br_taken_i;
      r_fifo_ghr[r_wptr]   <= r_ghr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ghr      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_taken    <= 1'b0;
      r_snap     <= '0;
      r_lane     <= '0;
    end else begin
      // History advances on every resolution, whether or not the entry fits.
      if (ex_br_valid_i) r_ghr <= {r_ghr[GHRLen-2:0], ex_br_taken_i};
      if (ex_br_valid_i && !w_push && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_push) r_wptr <= (r_wptr == PtrW'(UpdFifoDepth - 1)) ? '0 : r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PtrW'(UpdFifoDepth - 1)) ? '0 : r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: ;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_idx   <= r_fifo_idx[r_rptr];
            r_taken <= r_fifo_taken[r_rptr];
            r_snap  <= r_fifo_ghr[r_rptr];
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_lane  <= '0;
          r_state <= w_train ? S_WRITE : S_IDLE;
        end
        S_WRITE: begin
          if (r_lane == LaneW'(NSteps - 1)) r_state <= S_IDLE;
          else                              r_lane  <= r_lane + LaneW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < PTableSize; r++) begin
        r_bias[r] <= '0;
        r_w[r]    <= '0;
      end
    end else if (r_state == S_WRITE) begin
      if (r_lane == '0) r_bias[r_idx] <= sat_step(r_bias[r_idx], r_taken);
      for (int j = 0; j < GHRLen; j++) begin
        if (LaneW'(j / Lanes) == r_lane)
          r_w[r_idx][j] <= sat_step(r_w[r_idx][j], r_taken == r_snap[j]);
      end
    end
  end

  assign train_busy_o   = (r_state != S_IDLE) || (r_count != '0);
  assign upd_drop_cnt_o = r_drop_cnt;
endmodule

// File: tb/tb_bp_perceptron_hashed.sv
// Bench for bp_perceptron_hashed: three small instances (base, wide threshold, GHR-hashed)
// share one stimulus stream; each test checks the instance it targets.
module tb_bp_perceptron_hashed;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fetch_rdata = '0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_valid = 1'b0;
  logic [31:0] ex_addr = '0;
  logic        ex_taken = 1'b0;
  logic        ex_valid = 1'b0;

  logic a_taken, b_taken, c_taken, a_busy, b_busy, c_busy;
  logic [31:0] a_pc, b_pc, c_pc;
  logic [15:0] a_drop, b_drop, c_drop;

  localparam int SEL_A = 0;
  localparam int SEL_B = 1;
  localparam int SEL_C = 2;

  always #5 clk = ~clk;

  bp_perceptron_hashed #(.PTableSize(16), .PWeightLen(5), .GHRLen(4), .Theta(8), .Lanes(2),
                         .UpdFifoDepth(2), .HashGhr(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .fetch_rdata_i(fetch_rdata), .fetch_pc_i(fetch_pc),
    .fetch_valid_i(fetch_valid), .predict_branch_taken_o(a_taken), .predict_branch_pc_o(a_pc),
    .ex_br_instr_addr_i(ex_addr), .ex_br_taken_i(ex_taken), .ex_br_valid_i(ex_valid),
    .train_busy_o(a_busy), .upd_drop_cnt_o(a_drop));

  bp_perceptron_hashed #(.PTableSize(16), .PWeightLen(5), .GHRLen(4), .Theta(255), .Lanes(2),
                         .UpdFifoDepth(2), .HashGhr(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .fetch_rdata_i(fetch_rdata), .fetch_pc_i(fetch_pc),
    .fetch_valid_i(fetch_valid), .predict_branch_taken_o(b_taken), .predict_branch_pc_o(b_pc),
    .ex_br_instr_addr_i(ex_addr), .ex_br_taken_i(ex_taken), .ex_br_valid_i(ex_valid),
    .train_busy_o(b_busy), .upd_drop_cnt_o(b_drop));

  bp_perceptron_hashed #(.PTableSize(16), .PWeightLen(5), .GHRLen(4), .Theta(8), .Lanes(2),
                         .UpdFifoDepth(2), .HashGhr(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst), .fetch_rdata_i(fetch_rdata), .fetch_pc_i(fetch_pc),
    .fetch_valid_i(fetch_valid), .predict_branch_taken_o(c_taken), .predict_branch_pc_o(c_pc),
    .ex_br_instr_addr_i(ex_addr), .ex_br_taken_i(ex_taken), .ex_br_valid_i(ex_valid),
    .train_busy_o(c_busy), .upd_drop_cnt_o(c_drop));

  typedef struct {
    string       name;
    int          sel;
    logic        exp_taken;
    logic [31:0] exp_pc;
    bit          chk_pc;
  } pred_exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        exp_taken;
    logic [31:0] exp_pc;
    bit          chk_pc;
  } vec_t;

  pred_exp_t sb_q[$];
  vec_t      vecs[9];
  int        checks = 0;
  int        errors = 0;

  function automatic logic get_taken(input int sel);
    case (sel)
      SEL_A:   return a_taken;
      SEL_B:   return b_taken;
      default: return c_taken;
    endcase
  endfunction

  function automatic logic [31:0] get_pc(input int sel);
    case (sel)
      SEL_A:   return a_pc;
      SEL_B:   return b_pc;
      default: return c_pc;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      SEL_A:   return a_busy;
      SEL_B:   return b_busy;
      default: return c_busy;
    endcase
  endfunction

  function automatic logic [15:0] get_drop(input int sel);
    case (sel)
      SEL_A:   return a_drop;
      SEL_B:   return b_drop;
      default: return c_drop;
    endcase
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_sb();
    pred_exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({e.name, ".taken"}, 32'(get_taken(e.sel)), 32'(e.exp_taken));
      if (e.chk_pc) check_val({e.name, ".pc"}, get_pc(e.sel), e.exp_pc);
    end
  endtask

  task automatic pred_check(input string name, input int sel, input logic [31:0] instr,
                            input logic [31:0] pc, input logic valid, input logic exp_taken,
                            input logic [31:0] exp_pc, input bit chk_pc);
    pred_exp_t e;
    fetch_rdata = instr;
    fetch_pc    = pc;
    fetch_valid = valid;
    e.name = name; e.sel = sel; e.exp_taken = exp_taken; e.exp_pc = exp_pc; e.chk_pc = chk_pc;
    sb_q.push_back(e);
    #1;
    drain_sb();
  endtask

  task automatic beq_check(input string name, input int sel, input logic [31:0] pc,
                           input logic exp_taken);
    pred_check(name, sel, 32'h0000_0063, pc, 1'b1, exp_taken, pc, 1'b1);
  endtask

  task automatic push_update(input logic [31:0] pc, input logic taken);
    ex_addr  = pc;
    ex_taken = taken;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic wait_idle(input int sel, input string name);
    int n;
    n = 0;
    while (get_busy(sel) && (n < 200)) begin
      tick();
      n++;
    end
    check_val({name, ".idle"}, 32'(get_busy(sel)), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"beq_zero",    32'h0000_0063, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0100, 1'b1};
    vecs[1] = '{"jal_p8",      32'h0080_006F, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0208, 1'b1};
    vecs[2] = '{"addi",        32'h0000_0013, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3] = '{"jal_invalid", 32'h0080_006F, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0208, 1'b1};
    vecs[4] = '{"cj_p8",       32'h0000_A021, 32'h0000_0400, 1'b1, 1'b1, 32'h0000_0408, 1'b1};
    vecs[5] = '{"cbeqz_m254",  32'h0000_D009, 32'h0000_0500, 1'b1, 1'b1, 32'h0000_0402, 1'b1};
    vecs[6] = '{"bne_m4",      32'hFE00_1EE3, 32'h0000_0600, 1'b1, 1'b1, 32'h0000_05FC, 1'b1};
    vecs[7] = '{"jal_m8",      32'hFF9F_F06F, 32'h0000_0700, 1'b1, 1'b1, 32'h0000_06F8, 1'b1};
    vecs[8] = '{"c_nop",       32'h0000_0001, 32'h0000_0800, 1'b1, 1'b0, 32'h0000_0000, 1'b0};

    do_reset();
    check_val("rst.busy_a", 32'(a_busy), 32'd0);
    check_val("rst.busy_b", 32'(b_busy), 32'd0);
    check_val("rst.busy_c", 32'(c_busy), 32'd0);
    check_val("rst.drop_a", 32'(a_drop), 32'd0);
    check_val("rst.drop_c", 32'(c_drop), 32'd0);

    // Decode and target table against the freshly reset table (y = 0).
    for (int i = 0; i < 9; i++) begin
      pred_check({"t1.", vecs[i].name}, SEL_A, vecs[i].instr, vecs[i].pc, vecs[i].valid,
                 vecs[i].exp_taken, vecs[i].exp_pc, vecs[i].chk_pc);
      tick();
    end

    // One not-taken update: busy t+1..t+4, partial row visible at t+4, full row at t+5.
    ex_addr = 32'h100; ex_taken = 1'b0; ex_valid = 1'b1;
    #1;
    check_val("t2.busy_t0", 32'(a_busy), 32'd0);
    tick();
    ex_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check_val($sformatf("t2.busy_t%0d", k), 32'(a_busy), 32'(k <= 4));
      if (k >= 3) beq_check($sformatf("t2.pred_t%0d", k), SEL_A, 32'h100, 1'(k == 3));
      if (k < 5) tick();
    end
    push_update(32'h100, 1'b0);
    wait_idle(SEL_A, "t2.upd2");
    beq_check("t2.pred_after2", SEL_A, 32'h100, 1'b0);
    // y = -10 is correct and beyond Theta, so the third entry only goes IDLE->EVAL->IDLE.
    push_update(32'h100, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      check_val($sformatf("t2.notrain_busy_t%0d", k), 32'(a_busy), 32'(k <= 2));
      if (k < 3) tick();
    end

    // Saturation with a threshold that always trains.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push_update(32'h100, 1'b0);
      repeat (4) tick();
    end
    wait_idle(SEL_B, "t3.drain");
    check_val("t3.drop_b", 32'(b_drop), 32'd0);
    beq_check("t3.pred_ghr0000", SEL_B, 32'h100, 1'b0);
    push_update(32'h318, 1'b1);
    wait_idle(SEL_B, "t3.ghr1");
    push_update(32'h318, 1'b1);
    wait_idle(SEL_B, "t3.ghr2");
    beq_check("t3.pred_ghr0011", SEL_B, 32'h100, 1'b0);
    push_update(32'h318, 1'b1);
    wait_idle(SEL_B, "t3.ghr3");
    beq_check("t3.pred_ghr0111", SEL_B, 32'h100, 1'b1);

    // Six back-to-back updates into a 2-deep FIFO: pushes 4 and 5 are dropped.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ex_addr = 32'h318; ex_taken = 1'b0; ex_valid = 1'b1;
      tick();
    end
    ex_valid = 1'b0;
    check_val("t4.drop_b", 32'(b_drop), 32'd2);
    for (int k = 6; k <= 17; k++) begin
      check_val($sformatf("t4.busy_c%0d", k), 32'(b_busy), 32'(k <= 16));
      if (k < 17) tick();
    end

    // Reset asserted in the second WRITE cycle clears the partially written row at once.
    wait_idle(SEL_A, "t5.pre");
    push_update(32'h100, 1'b0);
    repeat (3) tick();
    check_val("t5.busy_write2", 32'(a_busy), 32'd1);
    beq_check("t5.pred_partial", SEL_A, 32'h100, 1'b0);
    rst = 1'b1;
    #1;
    check_val("t5.busy_rst", 32'(a_busy), 32'd0);
    check_val("t5.drop_b_rst", 32'(get_drop(SEL_B)), 32'd0);
    beq_check("t5.pred_rst", SEL_A, 32'h100, 1'b1);
    tick();
    rst = 1'b0;
    tick();

    // GHR hashing: with GHR=0011 pc 0x100 moves to an untrained row; 0x10C reaches the trained one.
    push_update(32'h100, 1'b0);
    wait_idle(SEL_C, "t6.train");
    beq_check("t6.pred_ghr0000", SEL_C, 32'h100, 1'b0);
    push_update(32'h318, 1'b1);
    wait_idle(SEL_C, "t6.ghr1");
    push_update(32'h318, 1'b1);
    wait_idle(SEL_C, "t6.ghr2");
    beq_check("t6.pred_hashed_new_row", SEL_C, 32'h100, 1'b1);
    beq_check("t6.pred_hashed_old_row", SEL_C, 32'h10C, 1'b0);
    beq_check("t6.pred_unhashed", SEL_A, 32'h100, 1'b0);
    check_val("t6.sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
